// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The datapath reports ID/EX hazard sources; the controller returns pipeline-register write/flush gates.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       ex_md;
    logic       ex_branch_taken;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       md_start;
    logic       md_done;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt, ex_md, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush,
               md_start, md_done
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt, ex_md, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush,
               md_start, md_done
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage MIPS hazard controller: load-use stall, taken-branch squash, fixed-latency mult/div hold in EX.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / squash_events counters.
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          squash_events
`endif
);
    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;
    logic             pc_write, if_id_write, if_id_flush;
    logic             id_ex_write, id_ex_flush, ex_mem_flush;
    logic             md_start, md_done;

    // $0 is hardwired zero, so a load targeting it never produces a real dependency
    assign load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_start     = 1'b0;
        md_done      = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (hz.ex_md) begin
                        md_start     = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_nxt    = MD_BUSY;
                        cnt_nxt      = MD_LOAD;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    // branch/load-use inputs are ignored: EX holds the mult/div and ID is frozen
                    if (cnt != '0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        cnt_nxt      = cnt - 1'b1;
                    end else begin
                        md_done   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_write  = id_ex_write;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.md_start     = md_start;
    assign hz.md_done      = md_done;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            squash_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if ((state == RUN) && hz.ex_branch_taken && (squash_events != 32'hFFFF_FFFF))
                squash_events <= squash_events + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table of per-cycle vectors plus hand sequences, scored through a queue.
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       md;
        logic       br;
    } vin_t;

    typedef struct {
        vin_t       in;
        logic [7:0] exp;
        string      name;
    } vec_t;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, md_start, md_done}
    localparam logic [7:0] O_RST = 8'b0010_1100;
    localparam logic [7:0] O_DEF = 8'b1101_0000;
    localparam logic [7:0] O_LU  = 8'b0001_1000;
    localparam logic [7:0] O_BR  = 8'b1111_1000;
    localparam logic [7:0] O_MDI = 8'b0000_0110;
    localparam logic [7:0] O_MDB = 8'b0000_0100;
    localparam logic [7:0] O_MDD = 8'b1101_0001;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    vec_t       vecs[$];

    pipeline_hazard_ctrl_if hz();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, squash_events;
`endif

    pipeline_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .squash_events(squash_events)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic vin_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic mr,
                                input logic [4:0] ert, input logic md, input logic br);
        vin_t v;
        v.rst = r; v.id_rs = rs; v.id_rt = rt; v.uses_rs = urs; v.uses_rt = urt;
        v.memread = mr; v.ex_rt = ert; v.md = md; v.br = br;
        return v;
    endfunction

    function automatic vec_t vc(input vin_t v, input logic [7:0] e, input string nm);
        vec_t x;
        x.in = v; x.exp = e; x.name = nm;
        return x;
    endfunction

    // Drive one cycle, queue the expectation, score it on the falling edge, then let the posedge commit.
    task automatic step(input vin_t v, input logic [7:0] e, input string nm);
        logic [7:0] act, want;
        string      wn;
        rst                = v.rst;
        hz.id_rs           = v.id_rs;
        hz.id_rt           = v.id_rt;
        hz.id_uses_rs      = v.uses_rs;
        hz.id_uses_rt      = v.uses_rt;
        hz.ex_memread      = v.memread;
        hz.ex_rt           = v.ex_rt;
        hz.ex_md           = v.md;
        hz.ex_branch_taken = v.br;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        act  = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
                hz.id_ex_flush, hz.ex_mem_flush, hz.md_start, hz.md_done};
        want = exp_q.pop_front();
        wn   = name_q.pop_front();
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", wn, act, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vin_t idle, rs8;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rs8  = mk(0, 8, 0, 1, 0, 1, 8, 0, 0);

        vecs.push_back(vc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), O_RST, "reset0"));
        vecs.push_back(vc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), O_RST, "reset1"));
        vecs.push_back(vc(idle,                          O_DEF, "run_default"));
        vecs.push_back(vc(rs8,                           O_LU,  "loaduse_rs"));
        vecs.push_back(vc(idle,                          O_DEF, "after_bubble"));
        vecs.push_back(vc(mk(0, 0, 0, 1, 0, 1, 0, 0, 0), O_DEF, "reg0_no_stall"));
        vecs.push_back(vc(mk(0, 9, 0, 1, 0, 1, 8, 0, 0), O_DEF, "rs_mismatch"));
        vecs.push_back(vc(mk(0, 0, 5, 0, 1, 1, 5, 0, 0), O_LU,  "loaduse_rt"));
        vecs.push_back(vc(mk(0, 0, 5, 0, 0, 1, 5, 0, 0), O_DEF, "rt_not_used"));
        vecs.push_back(vc(mk(0, 8, 0, 1, 0, 0, 8, 0, 0), O_DEF, "not_a_load"));
        vecs.push_back(vc(mk(0, 8, 0, 1, 0, 1, 8, 0, 1), O_BR,  "branch_over_lu"));
        vecs.push_back(vc(mk(0, 8, 0, 1, 0, 1, 8, 1, 1), O_BR,  "branch_over_md"));
        vecs.push_back(vc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_MDI, "md_issue"));
        vecs.push_back(vc(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), O_MDB, "md_busy_br_ign"));
        vecs.push_back(vc(mk(0, 8, 0, 1, 0, 1, 8, 1, 0), O_MDB, "md_busy_lu_ign"));
        vecs.push_back(vc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_MDD, "md_done"));
        vecs.push_back(vc(idle,                          O_DEF, "md_back_run"));

        foreach (vecs[i]) step(vecs[i].in, vecs[i].exp, vecs[i].name);

        // reset while MD_BUSY with cnt==1 abandons the op without md_done
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_MDI, "abort_issue");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_MDB, "abort_busy");
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), O_RST, "abort_rst");
        step(idle,                          O_DEF, "abort_run");
        step(idle,                          O_DEF, "abort_run2");

        // a second load-use right after a mult/div completes still takes exactly one bubble
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_MDI, "md2_issue");
        step(idle,                          O_MDB, "md2_busy0");
        step(idle,                          O_MDB, "md2_busy1");
        step(rs8,                           O_MDD, "md2_done_lu_ign");
        step(rs8,                           O_LU,  "md2_then_lu");
        step(idle,                          O_DEF, "md2_idle");

`ifdef HAZARD_PERF_EN
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), O_RST, "perf_rst");
        @(negedge clk);
        total++;
        if (stall_cycles !== 32'd0 || squash_events !== 32'd0) begin
            bad++;
            $display("FAIL perf_clear: got %0d/%0d want 0/0", stall_cycles, squash_events);
        end
        @(posedge clk); #1;
        step(rs8,                           O_LU,  "perf_lu");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_MDI, "perf_md0");
        step(idle,                          O_MDB, "perf_md1");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_MDB, "perf_md2_br_ign");
        step(idle,                          O_MDD, "perf_md3");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_BR,  "perf_br0");
        step(idle,                          O_DEF, "perf_gap");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_BR,  "perf_br1");
        step(idle,                          O_DEF, "perf_tail");
        @(negedge clk);
        total++;
        if (stall_cycles !== 32'd4) begin
            bad++;
            $display("FAIL perf_stall: got %0d want 4", stall_cycles);
        end
        total++;
        if (squash_events !== 32'd2) begin
            bad++;
            $display("FAIL perf_squash: got %0d want 2", squash_events);
        end
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, IF_ID, ID_EX and EX_MEM pipeline registers. It resolves three cases: load-use stalls, taken-branch squashes, and holding a multi-cycle mult/div instruction in EX for a fixed latency. The block sits beside the pipeline registers and its outputs gate their clock-edge updates.

Parameters:
MD_CYCLES, 4, total cycles a mult/div instruction occupies EX (legal range 2..2**CNT_W+1)
CNT_W, 4, width of the mult/div down-counter

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
id_rs  input  5  source register rs of the instruction in ID
id_rt  input  5  source register rt of the instruction in ID
id_uses_rs  input  1  the ID instruction reads rs
id_uses_rt  input  1  the ID instruction reads rt
ex_memread  input  1  the EX instruction is a load
ex_rt  input  5  destination register of the load in EX
ex_md  input  1  the EX instruction is mult/div
ex_branch_taken  input  1  a branch or jump resolved taken in EX
pc_write  output  1  PC update enable
if_id_write  output  1  IF_ID update enable
if_id_flush  output  1  IF_ID loads a bubble (all zero)
id_ex_write  output  1  ID_EX update enable (0 = hold)
id_ex_flush  output  1  ID_EX loads a bubble
ex_mem_flush  output  1  EX_MEM loads a bubble
md_start  output  1  one-cycle pulse to the MDU: operands are valid
md_done  output  1  one-cycle pulse: the mult/div result is valid and EX releases

Behaviour:
- State register: RUN, MD_BUSY. Counter cnt is CNT_W bits wide.
- rst=1: next state is RUN and next cnt is 0. During that cycle the outputs are forced: all *_write=0, all *_flush=1, md_start=0, md_done=0. A reset during MD_BUSY abandons the operation; no md_done is issued.
- Default (RUN, no event): all writes=1, all flushes=0, md pulses 0.
- Priority in RUN, highest first: ex_branch_taken, then ex_md, then load-use.
- Branch (RUN and ex_branch_taken): if_id_flush=1 and id_ex_flush=1. Writes stay 1, so the PC takes the target from the datapath. Any load-use condition is ignored that cycle. Squash latency is one cycle; state stays RUN.
- Mult/div issue (RUN and ex_md, no branch): md_start=1, pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1. Next state is MD_BUSY and cnt is loaded with MD_CYCLES-2.
- MD_BUSY with cnt!=0: same stall outputs as issue, with md_start=0. cnt decrements.
- MD_BUSY with cnt==0: release. md_done=1, all writes=1, all flushes=0. Next state is RUN.
- Total: the EX occupancy is MD_CYCLES cycles, of which MD_CYCLES-1 are stall cycles. The PC is frozen for exactly MD_CYCLES-1 cycles.
- In MD_BUSY, ex_branch_taken and the load-use inputs are ignored (EX holds mult/div and ID is frozen).
- Load-use (RUN, no branch, no ex_md): hazard = ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
  - On hazard: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Exactly one bubble is inserted. The next cycle the load has moved to MEM, so the condition clears and forwarding covers the operand.
- Register $0 never causes a stall.
- Outputs are combinational from state, cnt, rst and the inputs. There are no combinational paths from outputs back to inputs.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds output ports stall_cycles [31:0] and squash_events [31:0].
  - stall_cycles increments on every non-reset cycle with pc_write=0.
  - squash_events increments on every non-reset cycle in RUN with ex_branch_taken=1.
  - Both counters are cleared by rst and saturate at 32'hFFFFFFFF.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset for 2 cycles, then release with all inputs 0 -> during rst: writes=0, flushes=1. First cycle after release: pc_write=1, if_id_write=1, id_ex_write=1, flushes=0.
- ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. Repeat with ex_rt=0 -> no stall.
- ex_md=1 with MD_CYCLES=4 -> md_start pulses in cycle 0. pc_write=0 in cycles 0-2. md_done=1 with all writes=1 in cycle 3. State returns to RUN.
- ex_branch_taken=1 together with a load-use match -> if_id_flush=1 and id_ex_flush=1, pc_write=1, no stall. ex_branch_taken=1 in MD_BUSY -> ignored.
- Assert rst in MD_BUSY at cnt=1 -> no md_done. Next cycle is RUN defaults; ex_md=0 afterwards produces no stall.
- With HAZARD_PERF_EN: one load-use stall, one 4-cycle mult/div, and 2 branches -> stall_cycles=4, squash_events=2.
